// File: rtl/atb_trace_packer.sv
// ATB trace packer: gathers source trace bytes into 32-bit ATB words.
// Partial words close on flush, sync request or idle timeout.
module atb_trace_packer #(
  parameter logic [6:0]  ATID    = 7'h10,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        atclk,
  input  logic        atresetn,
  input  logic        atclken,
  input  logic        src_valid,
  input  logic [7:0]  src_data,
  output logic        src_ready,
  output logic [31:0] atdata,
  output logic [2:0]  atbytes,
  output logic [6:0]  atid,
  output logic        atvalid,
  input  logic        atready,
  input  logic        afvalid,
  output logic        afready,
  input  logic        syncreq,
  output logic        src_syncreq,
  output logic        atwakeup
);

  localparam int unsigned TW      = (TIMEOUT == 32'd0) ? 1 : $clog2(TIMEOUT + 32'd1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);

  // Reserved ATB IDs are rejected at elaboration.
  if ((ATID == 7'h00) || ((ATID >= 7'h70) && (ATID <= 7'h7C)) || (ATID >= 7'h7E)) begin : g_bad_atid
    $fatal(1, "atb_trace_packer: ATID is a reserved trace ID");
  end

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    ACK   = 2'd2
  } state_t;

  state_t        state_r;
  logic [31:0]   pack_r;
  logic [2:0]    cnt_r;
  logic [TW-1:0] tmo_r;
  logic          sync_pend_r;
  logic          alive_r;
  logic          atvalid_r;
  logic [31:0]   atdata_r;
  logic [2:0]    atbytes_r;
  logic          afready_r;
  logic          src_syncreq_r;

  logic          free_s;
  logic          src_ready_s;
  logic          acc_s;
  logic          tmo_hit_s;
  logic          close_s;
  logic          load_s;

  // Handshake, close-event and load decisions for the current cycle.
  always_comb begin
    free_s      = !atvalid_r || atready;
    src_ready_s = alive_r && (state_r == RUN) && ((cnt_r < 3'd4) || free_s);
    acc_s       = atclken && src_valid && src_ready_s;
    tmo_hit_s   = (TIMEOUT != 32'd0) && (tmo_r >= TMO_MAX);
    close_s     = (state_r == FLUSH) || syncreq || sync_pend_r || tmo_hit_s;
    load_s      = atclken && free_s &&
                  ((cnt_r == 3'd4) || ((cnt_r != 3'd0) && close_s));
  end

  // Packing register, byte count, idle timeout and pending sync close.
  always_ff @(posedge atclk or negedge atresetn) begin
    if (!atresetn) begin
      pack_r      <= 32'd0;
      cnt_r       <= 3'd0;
      tmo_r       <= '0;
      sync_pend_r <= 1'b0;
    end else if (atclken) begin
      if (load_s) begin
        // A byte arriving with the load starts the next word at lane 0.
        if (acc_s) begin
          pack_r <= {24'd0, src_data};
          cnt_r  <= 3'd1;
        end else begin
          pack_r <= 32'd0;
          cnt_r  <= 3'd0;
        end
      end else if (acc_s) begin
        pack_r[{cnt_r[1:0], 3'b000} +: 8] <= src_data;
        cnt_r <= cnt_r + 3'd1;
      end
      if (acc_s || load_s) begin
        tmo_r <= '0;
      end else if ((cnt_r != 3'd0) && (tmo_r != TMO_MAX)) begin
        tmo_r <= tmo_r + TW'(1);
      end
      sync_pend_r <= (syncreq || sync_pend_r) && !load_s && (cnt_r != 3'd0);
    end
  end

  // ATB output register; held stable while the sink stalls.
  always_ff @(posedge atclk or negedge atresetn) begin
    if (!atresetn) begin
      atvalid_r <= 1'b0;
      atdata_r  <= 32'd0;
      atbytes_r <= 3'd0;
    end else if (load_s) begin
      atvalid_r <= 1'b1;
      atdata_r  <= pack_r;
      atbytes_r <= cnt_r;
    end else if (atclken && atvalid_r && atready) begin
      atvalid_r <= 1'b0;
      atdata_r  <= 32'd0;
      atbytes_r <= 3'd0;
    end
  end

  // Flush state machine, sync forwarding and post-reset source enable.
  always_ff @(posedge atclk or negedge atresetn) begin
    if (!atresetn) begin
      state_r       <= RUN;
      afready_r     <= 1'b0;
      src_syncreq_r <= 1'b0;
      alive_r       <= 1'b0;
    end else if (atclken) begin
      alive_r       <= 1'b1;
      src_syncreq_r <= syncreq;
      case (state_r)
        RUN: begin
          if (afvalid) state_r <= FLUSH;
        end
        FLUSH: begin
          if ((cnt_r == 3'd0) && free_s) begin
            state_r   <= ACK;
            afready_r <= 1'b1;
          end
        end
        ACK: begin
          if (afvalid && afready_r) begin
            state_r   <= RUN;
            afready_r <= 1'b0;
          end
        end
        default: begin
          state_r   <= RUN;
          afready_r <= 1'b0;
        end
      endcase
    end
  end

  assign src_ready   = src_ready_s;
  assign atvalid     = atvalid_r;
  assign atdata      = atdata_r;
  assign atbytes     = atbytes_r;
  assign atid        = ATID;
  assign afready     = afready_r;
  assign src_syncreq = src_syncreq_r;
  assign atwakeup    = atvalid_r || (cnt_r != 3'd0) || (state_r != RUN);

endmodule

// File: tb/tb_atb_trace_packer.sv
// Bench for atb_trace_packer: directed scenarios plus random traffic,
// every cycle compared against a queue-based reference model.
module tb_atb_trace_packer;

  localparam logic [6:0] ATID = 7'h10;
  localparam int         TMO  = 16;

  logic        atclk = 1'b0;
  logic        atresetn, atclken, src_valid, atready, afvalid, syncreq;
  logic [7:0]  src_data;
  logic        src_ready, atvalid, afready, src_syncreq, atwakeup;
  logic [31:0] atdata;
  logic [2:0]  atbytes;
  logic [6:0]  atid;

  atb_trace_packer #(.ATID(ATID), .TIMEOUT(TMO)) dut (
    .atclk(atclk), .atresetn(atresetn), .atclken(atclken),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .atdata(atdata), .atbytes(atbytes), .atid(atid), .atvalid(atvalid),
    .atready(atready), .afvalid(afvalid), .afready(afready),
    .syncreq(syncreq), .src_syncreq(src_syncreq), .atwakeup(atwakeup)
  );

  always #5 atclk = ~atclk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: packed bytes as a queue, output word, flush phase.
  logic [7:0]  m_pk[$];
  bit          m_ov, m_afr, m_ssr, m_sp, m_alive, m_acc, m_ack_done;
  logic [31:0] m_ow;
  int          m_ob, m_st, m_idle;   // m_st: 0 run, 1 flushing, 2 acknowledging

  logic        o_valid, o_ready, o_afready, o_ssr;
  logic [31:0] o_data;
  logic [2:0]  o_bytes;

  function automatic void model_reset();
    m_pk.delete();
    m_ov = 1'b0; m_ow = 32'd0; m_ob = 0; m_st = 0; m_afr = 1'b0;
    m_ssr = 1'b0; m_sp = 1'b0; m_alive = 1'b0; m_idle = 0;
    m_acc = 1'b0; m_ack_done = 1'b0;
  endfunction

  function automatic void model_step();
    bit free, rdy, close, load;
    int n;
    m_acc = 1'b0;
    m_ack_done = 1'b0;
    if (atclken) begin
      n     = m_pk.size();
      free  = !m_ov || atready;
      rdy   = m_alive && (m_st == 0) && (n < 4 || free);
      close = (m_st == 1) || syncreq || m_sp || (TMO != 0 && m_idle >= TMO);
      load  = free && (n == 4 || (n > 0 && close));
      m_acc = src_valid && rdy;
      if (load) begin
        m_ow = 32'd0;
        foreach (m_pk[k]) m_ow = m_ow | (32'(m_pk[k]) << (8 * k));
        m_ob = n;
        m_ov = 1'b1;
        m_pk.delete();
      end else if (m_ov && atready) begin
        m_ov = 1'b0; m_ow = 32'd0; m_ob = 0;
      end
      if (m_acc) m_pk.push_back(src_data);
      if (m_acc || load) m_idle = 0;
      else if (n > 0) m_idle++;
      m_sp  = (syncreq || m_sp) && !load && (n != 0);
      m_ssr = syncreq;
      case (m_st)
        0: if (afvalid) m_st = 1;
        1: if (n == 0 && free) begin m_st = 2; m_afr = 1'b1; end
        2: if (afvalid && m_afr) begin m_st = 0; m_afr = 1'b0; m_ack_done = 1'b1; end
        default: m_st = 0;
      endcase
      m_alive = 1'b1;
    end
  endfunction

  task automatic compare_outputs();
    bit free, rdy;
    free = !m_ov || atready;
    rdy  = m_alive && (m_st == 0) && (m_pk.size() < 4 || free);
    check("atvalid",     32'(atvalid),     32'(m_ov));
    check("atdata",      atdata,           m_ov ? m_ow : 32'd0);
    check("atbytes",     32'(atbytes),     32'(m_ob));
    check("src_ready",   32'(src_ready),   32'(rdy));
    check("afready",     32'(afready),     32'(m_afr));
    check("src_syncreq", 32'(src_syncreq), 32'(m_ssr));
    check("atwakeup",    32'(atwakeup),    32'(m_ov || m_pk.size() != 0 || m_st != 0));
    check("atid",        32'(atid),        32'(ATID));
  endtask

  task automatic tick();
    @(negedge atclk);
    compare_outputs();
    o_valid = atvalid; o_data = atdata; o_bytes = atbytes;
    o_ready = src_ready; o_afready = afready; o_ssr = src_syncreq;
    @(posedge atclk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    atresetn = 1'b0;
    #1;
    model_reset();
    check("rst_atvalid",  32'(atvalid),     32'd0);
    check("rst_atdata",   atdata,           32'd0);
    check("rst_atbytes",  32'(atbytes),     32'd0);
    check("rst_afready",  32'(afready),     32'd0);
    check("rst_syncreq",  32'(src_syncreq), 32'd0);
    check("rst_wakeup",   32'(atwakeup),    32'd0);
    check("rst_srcready", 32'(src_ready),   32'd0);
    repeat (2) @(posedge atclk);
    #1;
    atresetn = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit seen;
    seen = 1'b0;
    src_valid = 1'b1;
    src_data  = b;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      seen = o_ready && atclken;
    end
    check("send_acc", 32'(seen), 32'd1);
    src_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      n++;
      if (o_valid) break;
    end
    check("wait_valid", 32'(o_valid), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  flush_req, seen_word;
    logic [31:0] fw_data;
    logic [2:0]  fw_bytes;
    atresetn = 1'b0; atclken = 1'b1; src_valid = 1'b0; src_data = 8'd0;
    atready = 1'b1; afvalid = 1'b0; syncreq = 1'b0;
    model_reset();
    do_reset();

    // Full word
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    wait_valid(n);
    check("w4_data",  o_data, 32'h44332211);
    check("w4_bytes", 32'(o_bytes), 32'd4);

    // Partial word closed by idle timeout
    send_byte(8'hAA); send_byte(8'hBB);
    wait_valid(n);
    check("tmo_latency", 32'(n - 1), 32'd17);
    check("tmo_data",    o_data, 32'h0000BBAA);
    check("tmo_bytes",   32'(o_bytes), 32'd2);

    // Sink stall with a second word packed behind
    atready = 1'b0;
    for (int b = 1; b <= 8; b++) send_byte(8'(b));
    src_valid = 1'b1; src_data = 8'h99;
    repeat (5) begin
      tick();
      check("stall_ready", 32'(o_ready), 32'd0);
      check("stall_data",  o_data, 32'h04030201);
    end
    src_valid = 1'b0;
    atready = 1'b1;
    tick(); tick();
    check("stall_next", o_data, 32'h08070605);
    repeat (3) tick();

    // Flush with one byte packed
    send_byte(8'h55);
    afvalid = 1'b1;
    seen_word = 1'b0; fw_data = 32'd0; fw_bytes = 3'd0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (o_valid) begin seen_word = 1'b1; fw_data = o_data; fw_bytes = o_bytes; end
      if (o_afready) break;
    end
    check("flush_afready", 32'(o_afready), 32'd1);
    check("flush_word",    32'(seen_word), 32'd1);
    check("flush_data",    fw_data, 32'h00000055);
    check("flush_bytes",   32'(fw_bytes), 32'd1);
    afvalid = 1'b0;
    tick();
    check("flush_done", 32'(o_afready), 32'd0);

    // Flush with nothing packed
    afvalid = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n++;
      if (o_afready) break;
    end
    check("flush_empty_lat", 32'(n - 1), 32'd2);
    afvalid = 1'b0;
    tick();

    // Sync request closes a 3-byte word
    send_byte(8'h61); send_byte(8'h62); send_byte(8'h63);
    syncreq = 1'b1;
    tick();
    syncreq = 1'b0;
    tick();
    check("sync_pulse", 32'(o_ssr), 32'd1);
    check("sync_valid", 32'(o_valid), 32'd1);
    check("sync_bytes", 32'(o_bytes), 32'd3);
    check("sync_data",  o_data, 32'h00636261);
    tick();
    check("sync_once", 32'(o_ssr), 32'd0);

    // Reset while a word is stalled on the bus
    atready = 1'b0;
    send_byte(8'hC1); send_byte(8'hC2); send_byte(8'hC3); send_byte(8'hC4);
    tick(); tick();
    check("pre_rst_valid", 32'(o_valid), 32'd1);
    do_reset();
    atready = 1'b1;
    repeat (6) tick();

    // Random traffic
    flush_req = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      atclken   = ($urandom_range(0, 9) != 0);
      src_valid = ($urandom_range(0, 9) < 6);
      src_data  = 8'($urandom);
      atready   = ($urandom_range(0, 9) < 7);
      syncreq   = ($urandom_range(0, 39) == 0);
      if (!flush_req && $urandom_range(0, 59) == 0) flush_req = 1'b1;
      afvalid = flush_req;
      if ($urandom_range(0, 499) == 0) do_reset();
      tick();
      if (m_ack_done) flush_req = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/atb_trace_packer.md
ATB_TRACE_PACKER -- requirements
Module: atb_trace_packer

Interface
REQ-001 Parameter ATID, default 7'h10: constant trace source ID driven on atid.
REQ-002 Parameter TIMEOUT, default 16: idle cycles before a partial word is closed; 0 disables the timeout.
REQ-003 Elaboration SHALL fail if ATID is 7'h00, 7'h70..7'h7C, 7'h7E or 7'h7F.
REQ-004 One clock, atclk; reset atresetn is asynchronous, active-low.
REQ-005 atclk  in  1  clock for all logic.
REQ-006 atresetn  in  1  async active-low reset.
REQ-007 atclken  in  1  clock enable; state advances and handshakes are sampled only when high.
REQ-008 src_valid  in  1  trace byte valid from the upstream source.
REQ-009 src_data  in  8  trace byte.
REQ-010 src_ready  out  1  byte accepted when src_valid && src_ready && atclken.
REQ-011 atdata  out  32  packed trace word.
REQ-012 atbytes  out  3  number of valid bytes in atdata, 1..4.
REQ-013 atid  out  7  trace ID, always equal to ATID.
REQ-014 atvalid  out  1  ATB transfer valid.
REQ-015 atready  in  1  ATB transfer accepted by the downstream sink.
REQ-016 afvalid  in  1  flush request from the sink.
REQ-017 afready  out  1  flush complete acknowledge.
REQ-018 syncreq  in  1  synchronisation request pulse from the sink.
REQ-019 src_syncreq  out  1  synchronisation request forwarded to the source.
REQ-020 atwakeup  out  1  activity indicator.

Function
REQ-021 Packing register SHALL hold 0..4 bytes; byte k of a word SHALL occupy atdata[8k+7:8k], with the first-accepted byte at k=0.
REQ-022 Output register SHALL be free when atvalid=0, or when atvalid && atready in the current enabled cycle.
REQ-023 Transfer SHALL be loaded when the output register is free and either 4 bytes are packed or, with 1..3 bytes packed, a close event is pending.
- Close events: flush, syncreq, timeout.
- Load latency: atvalid rises the cycle after the load condition.
REQ-024 While atvalid && !atready, atdata, atbytes and atvalid SHALL remain stable.
REQ-025 When atvalid=0, atdata and atbytes SHALL be 0.
REQ-026 src_ready SHALL equal (state==RUN) && (packed count < 4 || output register free).
REQ-027 Simultaneous word load and byte accept: the new byte SHALL go to k=0 and the count SHALL become 1.
REQ-028 Timeout counter SHALL increment on enabled cycles with count>0 and no byte accepted.
- Clears on accept or on word load.
- Reaching TIMEOUT raises a close event.
REQ-029 FSM states SHALL be RUN, FLUSH and ACK.
- RUN -> FLUSH: afvalid sampled high.
- FLUSH: src_ready=0; partial word closed. FLUSH -> ACK: count==0 and output register free.
- ACK: afready=1. ACK -> RUN: afvalid && afready sampled.
REQ-030 A byte accepted in the same cycle afvalid is first sampled SHALL be included in the flushed data.
REQ-031 Flush with the block empty SHALL assert afready exactly 2 enabled cycles after afvalid is sampled.
REQ-032 syncreq sampled high SHALL pulse src_syncreq for one cycle on the next enabled cycle and SHALL raise a close event.
REQ-033 atwakeup SHALL equal atvalid || count!=0 || state!=RUN.
REQ-034 With atclken=0, all registers SHALL hold and no handshake SHALL complete.

Reset
REQ-035 On atresetn low, outputs SHALL take these values asynchronously: atvalid=0, atdata=0, atbytes=0, afready=0, src_syncreq=0, atwakeup=0, src_ready=0.
REQ-036 On atresetn low, count and timeout SHALL clear and the FSM SHALL enter RUN; atid SHALL be ATID at all times.
REQ-037 A reset mid-transfer or mid-flush SHALL discard packed data; src_ready SHALL rise on the first enabled cycle after reset release.

Verification
REQ-038 Bytes 11,22,33,44, atready=1 -> one transfer: atdata=32'h44332211, atbytes=4, atid=ATID.
REQ-039 Bytes AA,BB, then idle with TIMEOUT=16 -> transfer atdata=32'h0000BBAA, atbytes=2, with atvalid rising 17 cycles after BB is accepted.
REQ-040 Full word with atready=0 for 5 cycles -> atdata stable, src_ready=0 once 4 further bytes are packed, and no data loss.
REQ-041 Byte 55 then afvalid=1 -> transfer atbytes=1, atdata=32'h00000055; afready pulses after the handshake; src_ready=0 throughout FLUSH and ACK.
REQ-042 syncreq pulse with 3 bytes packed -> src_syncreq=1 for one cycle, then a transfer with atbytes=3.
REQ-043 atresetn asserted during atvalid=1 -> atvalid=0 immediately and no stale word after reset release.
